// File: rtl/edge_gate_counter.sv
// edge_gate_counter
//   Counts rising edges of an asynchronous input over a fixed gate window
//   of GATE_CYCLES clk cycles. It reports each completed window's count
//   with a one-cycle valid pulse. With en_i held high, windows repeat back
//   to back with no gap cycle.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-high reset
//   sig_i       measured signal, asynchronous to clk
//   en_i        measurement enable (level); low outside the terminal cycle aborts
//   count_o     rising-edge count of the last completed window
//   valid_o     one-cycle pulse marking a new count_o
//   busy_o      high while arming or gating
//   overflow_o  last completed window saturated (saturating build only)
//
// Build option
//   EDGE_GATE_SAT_EN  defined: the accumulator saturates and overflow_o
//                     reports saturation.
//                     undefined: the accumulator wraps and overflow_o is 0.

module edge_gate_counter #(
   parameter int GATE_CYCLES = 1000,
   parameter int COUNT_W     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sig_i,
   input  logic               en_i,
   output logic [COUNT_W-1:0] count_o,
   output logic               valid_o,
   output logic               busy_o,
   output logic               overflow_o
);

   // The timer runs the arm period (SYNC_STAGES+1 cycles) and the gate window.
   localparam int TMR_SPAN = (GATE_CYCLES > SYNC_STAGES + 1) ? GATE_CYCLES : SYNC_STAGES + 1;
   localparam int TMR_W    = $clog2(TMR_SPAN);
   localparam logic [TMR_W-1:0] ARM_LAST  = TMR_W'(SYNC_STAGES);
   localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;

   state_t               state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 edge_q;
   logic                 rise;
   logic                 terminal;
   logic [TMR_W-1:0]     timer;
   logic [COUNT_W-1:0]   acc;
   logic [COUNT_W-1:0]   acc_inc;

   // Synchronizer chain plus the previous-value flop used for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise     = sync_q[SYNC_STAGES-1] & ~edge_q;
   assign terminal = (state == GATE) && (timer == GATE_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (en_i) state_nxt = ARM;
         ARM: begin
            if (!en_i)                  state_nxt = IDLE;
            else if (timer == ARM_LAST) state_nxt = GATE;
         end
         GATE: if (!en_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef EDGE_GATE_SAT_EN
   logic win_ovf;
   logic ovf_inc;

   // An edge arriving at full scale is dropped and flagged instead.
   always_comb begin
      acc_inc = acc;
      ovf_inc = win_ovf;
      if (rise) begin
         if (acc == '1) ovf_inc = 1'b1;
         else           acc_inc = acc + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_ovf    <= 1'b0;
         overflow_o <= 1'b0;
      end else if (state != GATE) begin
         win_ovf <= 1'b0;
      end else if (terminal) begin
         overflow_o <= ovf_inc;
         win_ovf    <= 1'b0;
      end else begin
         win_ovf <= ovf_inc;
      end
   end
`else
   always_comb acc_inc = acc + COUNT_W'(rise);

   assign overflow_o = 1'b0;
`endif

   // The terminal cycle reports acc_inc so that an edge in the last gate
   // cycle is included; the accumulator restarts for a back-to-back window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer   <= '0;
         acc     <= '0;
         count_o <= '0;
         valid_o <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         valid_o <= terminal;
         busy_o  <= (state_nxt != IDLE);
         case (state)
            GATE: begin
               if (terminal) begin
                  count_o <= acc_inc;
                  acc     <= '0;
                  timer   <= '0;
               end else begin
                  acc     <= acc_inc;
                  timer   <= timer + 1'b1;
               end
            end
            ARM: begin
               acc   <= '0;
               timer <= (timer == ARM_LAST) ? '0 : timer + 1'b1;
            end
            default: begin
               acc   <= '0;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/edge_gate_counter.md
EDGE_GATE_COUNTER -- requirements
Module: edge_gate_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 1000: gate window length in clk cycles, legal range 2 or more.
REQ-002 Parameter COUNT_W, default 16: width of the edge accumulator and of count_o.
REQ-003 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sig_i, legal range 2 or more.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sig_i  input  1  delayed measured signal from the upstream shift stage; asynchronous to clk.
REQ-007 en_i  input  1  measurement enable, level-sensitive.
REQ-008 count_o  output  COUNT_W  rising-edge count of the last completed window.
REQ-009 valid_o  output  1  one-cycle pulse marking a new count_o.
REQ-010 busy_o  output  1  high in ARM or GATE.
REQ-011 overflow_o  output  1  last completed window exceeded 2^COUNT_W-1 edges.

Function
REQ-012 sig_i SHALL pass through SYNC_STAGES flops; an edge-detect flop SHALL hold the previous synchronized value.
REQ-013 A rising edge SHALL be defined as synchronized value 1 with previous value 0, detected in one cycle.
REQ-014 The FSM SHALL have exactly three states: IDLE, ARM, GATE.
REQ-015 IDLE -> ARM when en_i=1; accumulator, window timer and window-overflow flag cleared.
REQ-016 ARM SHALL last SYNC_STAGES+1 cycles, counting no edges, to flush the synchronizer and prime the edge flop; then -> GATE.
REQ-017 GATE SHALL last exactly GATE_CYCLES cycles; timer counts 0..GATE_CYCLES-1; edges detected in every GATE cycle, first and last included, SHALL be counted.
REQ-018 On the terminal GATE cycle (timer = GATE_CYCLES-1), count_o SHALL load accumulator plus that cycle's edge, overflow_o SHALL load the window flag, and valid_o SHALL be 1 the following cycle only.
REQ-019 After the terminal cycle, the accumulator and timer SHALL clear; FSM SHALL stay in GATE with no gap cycle if en_i=1, else -> IDLE.
REQ-020 en_i=0 in any non-terminal ARM or GATE cycle SHALL abort to IDLE next cycle; partial count discarded; count_o, overflow_o unchanged; no valid_o.
REQ-021 count_o and overflow_o SHALL hold their values between valid_o pulses.
REQ-022 busy_o SHALL be a registered decode of state (ARM or GATE).
REQ-023 A sig_i level already high at ARM entry SHALL NOT count as an edge.

Reset
REQ-024 reset=1 SHALL immediately force state IDLE, count_o=0, valid_o=0, busy_o=0, overflow_o=0, and clear timer, accumulator and all synchronizer/edge flops, independent of clk.
REQ-025 After reset deasserts with en_i=1, the first valid_o SHALL occur SYNC_STAGES+1+GATE_CYCLES+1 cycles after the first clk edge.
REQ-026 reset asserted mid-window SHALL discard the window; no valid_o for it.

Configuration
REQ-027 Macro EDGE_GATE_SAT_EN defined: accumulator SHALL saturate at 2^COUNT_W-1, and the window flag SHALL set on any edge arriving at that value.
REQ-028 EDGE_GATE_SAT_EN undefined: accumulator SHALL wrap modulo 2^COUNT_W, and overflow_o SHALL be constant 0; port list identical in both builds.

Verification
REQ-029 GATE_CYCLES=10, SYNC_STAGES=2, en_i=1, sig_i toggles every clk (period 2) -> each valid_o shows count_o=5, overflow_o=0, pulses every 10 cycles.
REQ-030 sig_i held 1 before en_i rises and for two windows -> count_o=0 both windows.
REQ-031 COUNT_W=2, GATE_CYCLES=12, 5 edges per window -> with EDGE_GATE_SAT_EN count_o=3, overflow_o=1; without it count_o=1, overflow_o=0.
REQ-032 en_i dropped at GATE cycle 4 after a window reporting 5 -> no valid_o, busy_o=0 two cycles later, count_o stays 5.
REQ-033 reset pulsed asynchronously (between clk edges) at GATE cycle 6 -> count_o=0, valid_o=0, busy_o=0 before next clk edge; restart timing per REQ-025.
REQ-034 Single sig_i edge placed on the first and then the last GATE cycle of consecutive windows (after sync delay) -> count_o=1 in each window.
